ball_link_tx: RTL and testbench

BALL_LINK_TX -- requirements
Module: ball_link_tx

---
 rtl/ball_link_pkg.sv | 64 ++++++
 rtl/uart_byte_tx.sv | 88 ++++++++
 rtl/ball_link_tx.sv | 143 ++++++++++++++
 tb/tb_ball_link_tx.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ball_link_pkg.sv
// Shared constants, state encoding and frame byte mapping for the ball link transmitter.
// Optional feature: BALL_LINK_CHKSUM_EN appends an XOR checksum byte to each frame.
package ball_link_pkg;

  localparam logic [7:0] BALL_LINK_HDR = 8'hA5;

`ifdef BALL_LINK_CHKSUM_EN
  localparam int unsigned BALL_LINK_NUM_BYTES = 9;
`else
  localparam int unsigned BALL_LINK_NUM_BYTES = 8;
`endif

  localparam int unsigned BYTE_IDX_W = 4;
  localparam int unsigned UART_BIT_W = 4;

  // Bit slot positions within one 10-bit UART character.
  localparam logic [UART_BIT_W-1:0] UART_BIT_START     = 4'd0;
  localparam logic [UART_BIT_W-1:0] UART_BIT_LAST_DATA = 4'd8;
  localparam logic [UART_BIT_W-1:0] UART_BIT_STOP      = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_DONE  = 3'd4
  } link_state_e;

  // Ball state captured when a send is accepted.
  typedef struct packed {
    logic [9:0]  y;
    logic [7:0]  vy;
    logic [1:0]  grav;
    logic [19:0] speed;
  } ball_snap_t;

`ifdef BALL_LINK_CHKSUM_EN
  // XOR of the payload bytes; the header is not covered.
  function automatic logic [7:0] frame_checksum(input ball_snap_t s);
    frame_checksum = {s.y[9:8], 6'b0} ^ s.y[7:0] ^ s.vy ^ {6'b0, s.grav}
                   ^ s.speed[7:0] ^ s.speed[15:8] ^ {4'b0, s.speed[19:16]};
  endfunction
`endif

  // Byte at position idx of the frame built from snapshot s.
  function automatic logic [7:0] frame_byte(input ball_snap_t s,
                                            input logic [BYTE_IDX_W-1:0] idx);
    case (idx)
      4'd0:    frame_byte = BALL_LINK_HDR;
      4'd1:    frame_byte = {s.y[9:8], 6'b0};
      4'd2:    frame_byte = s.y[7:0];
      4'd3:    frame_byte = s.vy;
      4'd4:    frame_byte = {6'b0, s.grav};
      4'd5:    frame_byte = s.speed[7:0];
      4'd6:    frame_byte = s.speed[15:8];
      4'd7:    frame_byte = {4'b0, s.speed[19:16]};
`ifdef BALL_LINK_CHKSUM_EN
      4'd8:    frame_byte = frame_checksum(s);
`endif
      default: frame_byte = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// UART 8N1 byte serializer: start bit, 8 data bits LSB first, stop bit, each BAUD_DIV cycles.
// A start request on the last stop-bit cycle chains the next byte with no idle gap.
module uart_byte_tx
  import ball_link_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 217
) (
  input  logic       clk_25MHZ,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] byte_in,
  output logic       tx,
  output logic       start_end_c,
  output logic       data_end_c,
  output logic       byte_done_c
);

  localparam int unsigned CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);

  logic                  running_q, running_d;
  logic [CNT_W-1:0]      baud_cnt_q, baud_cnt_d;
  logic [UART_BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [7:0]            shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic                  baud_last_c;

  // Bit timing, slot strobes and next-bit selection.
  always_comb begin
    running_d  = running_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_d       = tx_q;

    baud_last_c = running_q && (baud_cnt_q == BAUD_LAST);
    start_end_c = baud_last_c && (bit_cnt_q == UART_BIT_START);
    data_end_c  = baud_last_c && (bit_cnt_q == UART_BIT_LAST_DATA);
    byte_done_c = baud_last_c && (bit_cnt_q == UART_BIT_STOP);

    if (start) begin
      running_d  = 1'b1;
      baud_cnt_d = '0;
      bit_cnt_d  = UART_BIT_START;
      shift_d    = byte_in;
      tx_d       = 1'b0;
    end else if (running_q) begin
      if (baud_last_c) begin
        baud_cnt_d = '0;
        if (bit_cnt_q == UART_BIT_STOP) begin
          running_d = 1'b0;
          bit_cnt_d = UART_BIT_START;
          tx_d      = 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q + UART_BIT_W'(1);
          if (bit_cnt_q < UART_BIT_LAST_DATA) begin
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
          end else begin
            tx_d = 1'b1;
          end
        end
      end else begin
        baud_cnt_d = baud_cnt_q + CNT_W'(1);
      end
    end
  end

  // Serializer state; the line idles high out of reset.
  always_ff @(posedge clk_25MHZ or posedge reset) begin
    if (reset) begin
      running_q  <= 1'b0;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
    end else begin
      running_q  <= running_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
    end
  end

  assign tx = tx_q;

endmodule

// File: rtl/ball_link_tx.sv
// Ball state frame transmitter: on a trigger rise, snapshots the ball inputs and sends
// header + payload bytes over UART 8N1 to the peer board.
// Optional feature: BALL_LINK_CHKSUM_EN adds a trailing XOR checksum byte.
module ball_link_tx
  import ball_link_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 217
) (
  input  logic        clk_25MHZ,
  input  logic        reset,
  input  logic        ball_send_trigger,
  input  logic [9:0]  ball_y,
  input  logic [7:0]  ball_vy,
  input  logic [1:0]  gravity_counter,
  input  logic [7:0]  ball_speed_reg0,
  input  logic [7:0]  ball_speed_reg1,
  input  logic [3:0]  ball_speed_reg2,
  output logic        tx,
  output logic        busy,
  output logic        tx_done,
  output logic [7:0]  frame_cnt
);

  localparam logic [BYTE_IDX_W-1:0] LAST_IDX = BYTE_IDX_W'(BALL_LINK_NUM_BYTES - 1);

  link_state_e           state_q, state_d;
  logic                  trig_cur_q, trig_cur_d;
  logic                  trig_prev_q, trig_prev_d;
  logic [BYTE_IDX_W-1:0] byte_idx_q, byte_idx_d;
  ball_snap_t            snap_q, snap_d;
  logic                  busy_q, busy_d;
  logic                  tx_done_q, tx_done_d;
  logic [7:0]            frame_cnt_q, frame_cnt_d;

  logic                  rise_c;
  logic                  ser_start_c;
  logic [7:0]            ser_byte_c;
  logic [BYTE_IDX_W-1:0] next_idx_c;
  logic                  start_end_c;
  logic                  data_end_c;
  logic                  byte_done_c;
  logic                  ser_tx;

  uart_byte_tx #(
    .BAUD_DIV (BAUD_DIV)
  ) u_uart_byte_tx (
    .clk_25MHZ   (clk_25MHZ),
    .reset       (reset),
    .start       (ser_start_c),
    .byte_in     (ser_byte_c),
    .tx          (ser_tx),
    .start_end_c (start_end_c),
    .data_end_c  (data_end_c),
    .byte_done_c (byte_done_c)
  );

  // Frame sequencer: edge detect, snapshot, byte stepping and completion bookkeeping.
  always_comb begin
    state_d     = state_q;
    trig_cur_d  = ball_send_trigger;
    trig_prev_d = trig_cur_q;
    byte_idx_d  = byte_idx_q;
    snap_d      = snap_q;
    frame_cnt_d = frame_cnt_q;
    ser_start_c = 1'b0;
    ser_byte_c  = 8'h00;

    rise_c     = trig_cur_q && !trig_prev_q;
    next_idx_c = byte_idx_q + BYTE_IDX_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (rise_c) begin
          state_d      = ST_START;
          byte_idx_d   = '0;
          snap_d.y     = ball_y;
          snap_d.vy    = ball_vy;
          snap_d.grav  = gravity_counter;
          snap_d.speed = {ball_speed_reg2, ball_speed_reg1, ball_speed_reg0};
          ser_start_c  = 1'b1;
          ser_byte_c   = BALL_LINK_HDR;
        end
      end
      ST_START: begin
        if (start_end_c) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (data_end_c) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (byte_done_c) begin
          if (byte_idx_q == LAST_IDX) begin
            state_d     = ST_DONE;
            frame_cnt_d = frame_cnt_q + 8'd1;
          end else begin
            state_d     = ST_START;
            byte_idx_d  = next_idx_c;
            ser_start_c = 1'b1;
            ser_byte_c  = frame_byte(snap_q, next_idx_c);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d    = (state_d != ST_IDLE);
    tx_done_d = (state_d == ST_DONE);
  end

  // Sequencer state and registered status outputs.
  always_ff @(posedge clk_25MHZ or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      trig_cur_q  <= 1'b0;
      trig_prev_q <= 1'b0;
      byte_idx_q  <= '0;
      snap_q      <= '0;
      busy_q      <= 1'b0;
      tx_done_q   <= 1'b0;
      frame_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      trig_cur_q  <= trig_cur_d;
      trig_prev_q <= trig_prev_d;
      byte_idx_q  <= byte_idx_d;
      snap_q      <= snap_d;
      busy_q      <= busy_d;
      tx_done_q   <= tx_done_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign tx        = ser_tx;
  assign busy      = busy_q;
  assign tx_done   = tx_done_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_ball_link_tx.sv
// Self-checking bench for ball_link_tx: decodes the serial line against a byte-level model.
// Define BALL_LINK_CHKSUM_EN for both bench and RTL to exercise the checksum byte.
module tb_ball_link_tx;

  localparam int unsigned BAUD_DIV = 4;
`ifdef BALL_LINK_CHKSUM_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic       clk_25MHZ = 1'b0;
  logic       reset;
  logic       ball_send_trigger;
  logic [9:0] ball_y;
  logic [7:0] ball_vy;
  logic [1:0] gravity_counter;
  logic [7:0] ball_speed_reg0;
  logic [7:0] ball_speed_reg1;
  logic [3:0] ball_speed_reg2;
  logic       tx;
  logic       busy;
  logic       tx_done;
  logic [7:0] frame_cnt;

  int n_total = 0;
  int n_bad = 0;
  int done_seen = 0;
  int exp_frames = 0;
  logic [7:0] exp_b [0:8];

  always #20 clk_25MHZ = ~clk_25MHZ;

  ball_link_tx #(
    .BAUD_DIV (BAUD_DIV)
  ) dut (
    .clk_25MHZ         (clk_25MHZ),
    .reset             (reset),
    .ball_send_trigger (ball_send_trigger),
    .ball_y            (ball_y),
    .ball_vy           (ball_vy),
    .gravity_counter   (gravity_counter),
    .ball_speed_reg0   (ball_speed_reg0),
    .ball_speed_reg1   (ball_speed_reg1),
    .ball_speed_reg2   (ball_speed_reg2),
    .tx                (tx),
    .busy              (busy),
    .tx_done           (tx_done),
    .frame_cnt         (frame_cnt)
  );

  // Count every cycle on which tx_done is seen high.
  always @(negedge clk_25MHZ) begin
    if (tx_done === 1'b1) done_seen++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected frame computed from the field definitions with plain arithmetic.
  task automatic build_expected(input int y, input int vy, input int g, input int spd);
    int x;
    exp_b[0] = 8'hA5;
    exp_b[1] = 8'(((y / 256) % 4) * 64);
    exp_b[2] = 8'(y % 256);
    exp_b[3] = 8'(vy);
    exp_b[4] = 8'(g % 4);
    exp_b[5] = 8'(spd % 256);
    exp_b[6] = 8'((spd / 256) % 256);
    exp_b[7] = 8'((spd / 65536) % 16);
    x = 0;
    for (int i = 1; i < 8; i++) x = x ^ int'(exp_b[i]);
    exp_b[8] = 8'(x);
  endtask

  task automatic drive_inputs(input int y, input int vy, input int g, input int spd);
    ball_y          = 10'(y);
    ball_vy         = 8'(vy);
    gravity_counter = 2'(g);
    ball_speed_reg0 = 8'(spd % 256);
    ball_speed_reg1 = 8'((spd / 256) % 256);
    ball_speed_reg2 = 4'((spd / 65536) % 16);
  endtask

  // Called on the negedge where the trigger was just raised; decodes and checks a whole frame.
  task automatic recv_frame(input string nm);
    int         lat;
    int         d0;
    logic [9:0] w;
    logic       unstable;
    d0  = done_seen;
    lat = 0;
    while (tx !== 1'b0 && lat < 20) begin
      @(negedge clk_25MHZ);
      lat++;
    end
    chk({nm, "_latency"}, 32'(lat), 32'd2);
    chk({nm, "_busy_on"}, 32'(busy), 32'd1);
    for (int i = 0; i < NB; i++) begin
      unstable = 1'b0;
      w = '0;
      for (int j = 0; j < 10; j++) begin
        for (int k = 0; k < int'(BAUD_DIV); k++) begin
          if (!(i == 0 && j == 0 && k == 0)) @(negedge clk_25MHZ);
          if (k == 0) w[j] = tx;
          else if (tx !== w[j]) unstable = 1'b1;
        end
      end
      chk($sformatf("%s_byte%0d", nm, i), 32'(w), 32'({1'b1, exp_b[i], 1'b0}));
      chk($sformatf("%s_bitlen%0d", nm, i), 32'(unstable), 32'd0);
    end
    exp_frames = (exp_frames + 1) % 256;
    @(negedge clk_25MHZ);
    chk({nm, "_done_tx"}, 32'(tx), 32'd1);
    chk({nm, "_done_pulse"}, 32'(tx_done), 32'd1);
    chk({nm, "_done_busy"}, 32'(busy), 32'd1);
    chk({nm, "_frame_cnt"}, 32'(frame_cnt), 32'(exp_frames));
    @(negedge clk_25MHZ);
    chk({nm, "_idle_busy"}, 32'(busy), 32'd0);
    chk({nm, "_idle_done"}, 32'(tx_done), 32'd0);
    chk({nm, "_done_count"}, 32'(done_seen - d0), 32'd1);
  endtask

  task automatic idle_gap();
    ball_send_trigger = 1'b0;
    repeat (3) @(negedge clk_25MHZ);
  endtask

  initial begin
    int y, vy, g, spd, d0, wait_cyc;

    reset = 1'b1;
    ball_send_trigger = 1'b0;
    drive_inputs(0, 0, 0, 0);
    repeat (3) @(negedge clk_25MHZ);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(tx_done), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk_25MHZ);

    // Reference frame: y=300, vy=-3, g=2, speed=270000.
    build_expected(300, -3, 2, 270000);
    drive_inputs(300, -3, 2, 270000);
    ball_send_trigger = 1'b1;
    recv_frame("basic");
    idle_gap();

    // Randomized frames.
    for (int r = 0; r < 5; r++) begin
      y   = int'($urandom_range(1023, 0));
      vy  = int'($urandom_range(255, 0));
      g   = int'($urandom_range(3, 0));
      spd = int'($urandom_range(1048575, 0));
      build_expected(y, vy, g, spd);
      drive_inputs(y, vy, g, spd);
      ball_send_trigger = 1'b1;
      recv_frame($sformatf("rand%0d", r));
      idle_gap();
    end

    // Inputs change right after the snapshot is taken.
    build_expected(300, -3, 2, 270000);
    drive_inputs(300, -3, 2, 270000);
    ball_send_trigger = 1'b1;
    fork
      recv_frame("snap");
      begin
        repeat (2) @(negedge clk_25MHZ);
        drive_inputs(0, 5, 1, 12345);
      end
    join
    idle_gap();

    // Second rise mid-frame is ignored.
    y   = int'($urandom_range(1023, 0));
    spd = int'($urandom_range(1048575, 0));
    build_expected(y, 77, 3, spd);
    drive_inputs(y, 77, 3, spd);
    ball_send_trigger = 1'b1;
    fork
      recv_frame("mid");
      begin
        repeat (100) @(negedge clk_25MHZ);
        ball_send_trigger = 1'b0;
        repeat (5) @(negedge clk_25MHZ);
        ball_send_trigger = 1'b1;
      end
    join
    repeat (50) @(negedge clk_25MHZ);
    chk("mid_no_restart", 32'(busy), 32'd0);
    chk("mid_frame_cnt", 32'(frame_cnt), 32'(exp_frames));
    idle_gap();

    // Trigger held high for 10000 cycles yields one frame.
    build_expected(1023, -128, 3, 1048575);
    drive_inputs(1023, -128, 3, 1048575);
    d0 = done_seen;
    ball_send_trigger = 1'b1;
    recv_frame("held");
    repeat (10000 - 10 * NB * int'(BAUD_DIV) - 4) @(negedge clk_25MHZ);
    chk("held_one_frame", 32'(done_seen - d0), 32'd1);
    chk("held_busy", 32'(busy), 32'd0);
    chk("held_frame_cnt", 32'(frame_cnt), 32'(exp_frames));
    idle_gap();

    // Reset asserted during byte 4 aborts the frame.
    build_expected(300, -3, 2, 270000);
    drive_inputs(300, -3, 2, 270000);
    d0 = done_seen;
    ball_send_trigger = 1'b1;
    wait_cyc = 0;
    while (tx !== 1'b0 && wait_cyc < 20) begin
      @(negedge clk_25MHZ);
      wait_cyc++;
    end
    chk("rst_mid_start", 32'(tx), 32'd0);
    repeat (3 * 10 * int'(BAUD_DIV) + 12) @(negedge clk_25MHZ);
    chk("rst_mid_busy_before", 32'(busy), 32'd1);
    #5;
    reset = 1'b1;
    ball_send_trigger = 1'b0;
    #1;
    chk("rst_mid_tx", 32'(tx), 32'd1);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_frame_cnt", 32'(frame_cnt), 32'd0);
    exp_frames = 0;
    repeat (2) @(negedge clk_25MHZ);
    reset = 1'b0;
    repeat (10 * NB * int'(BAUD_DIV) + 20) @(negedge clk_25MHZ);
    chk("rst_mid_no_done", 32'(done_seen - d0), 32'd0);
    chk("rst_mid_idle_tx", 32'(tx), 32'd1);
    chk("rst_mid_idle_busy", 32'(busy), 32'd0);

    // Normal operation resumes after the aborted frame.
    build_expected(512, 5, 0, 65536);
    drive_inputs(512, 5, 0, 65536);
    ball_send_trigger = 1'b1;
    recv_frame("post_rst");
    idle_gap();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
